lsu_mem_sequencer: RTL and testbench

Load/store sequencer inside the LSU. It accepts one warp-wide memory instruction per transaction, including the eight per-thread addresses produced by the AGU. It then issues them one lane at a time, in ascending lane order, to the single-ported data-memory interface. Load results are collected into a per-lane buffer and returned to the thread register file with a one-cycle completion pulse.

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lane_pick.sv | 28 ++
 rtl/lsu_mem_sequencer.sv | 155 +++++++++++++++
 tb/tb_lsu_mem_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU constants and the load/store sequencer state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lsu_pkg;

  // Lanes per warp; the AGU sizes its per-lane address vector from this too.
  localparam int NUM_THREADS = 8;
  localparam int LANE_W      = $clog2(NUM_THREADS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } seq_state_t;

endpackage

// File: rtl/lane_pick.sv
// Lowest-set-bit priority encoder: picks the next lane to issue.
// Latency: purely combinational.
// Backpressure: none (no handshake).
// Ports: i_mask  pending-lane mask
//        o_lane  index of the lowest set bit (0 when the mask is empty)
//        o_any   any bit of i_mask set
module lane_pick #(
  parameter int N  = 8,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  i_mask,
  output logic [LW-1:0] o_lane,
  output logic          o_any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_lane = '0;
    o_any  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_lane = LW'(i);
        o_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// Serialises one warp-wide LD/ST into per-lane requests on a single-ported data memory.
// Latency: first mem request the cycle after acceptance; store 1 cycle/lane, load 2+ cycles/lane, then a 1-cycle done pulse.
// Backpressure: request held stable until mem_req_ready; req_ready only in IDLE; one outstanding memory request.
// Ports: clk/reset (sync, active-low); req_* + agu_addr/st_data from scheduler/AGU/RF;
//        mem_req_* / mem_rsp_* to data memory; done_* + ld_data to the thread register file; busy.
module lsu_mem_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_THREADS = lsu_pkg::NUM_THREADS
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic                                   req_is_store,
  input  logic [1:0]                             req_warp,
  input  logic [NUM_THREADS-1:0]                 req_mask,
  input  logic [NUM_THREADS-1:0][ADDR_WIDTH-1:0] agu_addr,
  input  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] st_data,
  output logic                                   mem_req_valid,
  input  logic                                   mem_req_ready,
  output logic                                   mem_req_we,
  output logic [ADDR_WIDTH-1:0]                  mem_req_addr,
  output logic [DATA_WIDTH-1:0]                  mem_req_wdata,
  input  logic                                   mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]                  mem_rsp_data,
  output logic                                   done_valid,
  output logic [1:0]                             done_warp,
  output logic                                   done_is_store,
  output logic [NUM_THREADS-1:0]                 done_mask,
  output logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] ld_data,
  output logic                                   busy
);

  import lsu_pkg::*;

  localparam int LW = $clog2(NUM_THREADS);

  seq_state_t                            r_state;
  seq_state_t                            w_state_nxt;
  logic                                  r_is_store;
  logic [1:0]                            r_warp;
  logic [NUM_THREADS-1:0]                r_orig_mask;
  logic [NUM_THREADS-1:0]                r_pend_mask;
  logic [NUM_THREADS-1:0][ADDR_WIDTH-1:0] r_addr;
  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] r_st;
  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] r_ld;
  logic [LW-1:0]                         r_lane;
  logic [LW-1:0]                         w_pick_lane;
  logic [LW-1:0]                         w_clr_lane;
  logic                                  w_any;
  logic                                  w_hs;
  logic [NUM_THREADS-1:0]                w_pend_clr;

  lane_pick #(.N(NUM_THREADS)) u_lane_pick (
    .i_mask (r_pend_mask),
    .o_lane (w_pick_lane),
    .o_any  (w_any)
  );

  // In WAIT_RSP the lane recorded at the load handshake is the one retired.
  assign w_clr_lane = (r_state == WAIT_RSP) ? r_lane : w_pick_lane;
  assign w_pend_clr = r_pend_mask & ~(NUM_THREADS'(1) << w_clr_lane);
  assign w_hs       = (r_state == ISSUE) && w_any && mem_req_ready;
  assign busy       = (r_state != IDLE);
  assign ld_data    = r_ld;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and all handshake/output decode; memory-side outputs depend only on registers.
  always_comb begin
    w_state_nxt   = r_state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    done_valid    = 1'b0;
    done_warp     = '0;
    done_is_store = 1'b0;
    done_mask     = '0;
    unique case (r_state)
      IDLE: begin
        req_ready = reset;
        if (req_valid) w_state_nxt = (req_mask == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        mem_req_valid = w_any;
        mem_req_we    = r_is_store;
        mem_req_addr  = r_addr[w_pick_lane];
        mem_req_wdata = r_is_store ? r_st[w_pick_lane] : '0;
        if (w_hs) begin
          if (!r_is_store)            w_state_nxt = WAIT_RSP;
          else if (w_pend_clr == '0)  w_state_nxt = DONE;
          else                        w_state_nxt = ISSUE;
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) w_state_nxt = (w_pend_clr == '0) ? DONE : ISSUE;
      end
      DONE: begin
        done_valid    = 1'b1;
        done_warp     = r_warp;
        done_is_store = r_is_store;
        done_mask     = r_orig_mask;
        w_state_nxt   = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_is_store  <= 1'b0;
      r_warp      <= '0;
      r_orig_mask <= '0;
      r_pend_mask <= '0;
      r_addr      <= '0;
      r_st        <= '0;
      r_ld        <= '0;
      r_lane      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_is_store  <= req_is_store;
            r_warp      <= req_warp;
            r_orig_mask <= req_mask;
            r_pend_mask <= req_mask;
            r_addr      <= agu_addr;
            r_st        <= st_data;
            r_ld        <= '0;
          end
        end
        ISSUE: begin
          if (w_hs) begin
            if (r_is_store) r_pend_mask <= w_pend_clr;
            else            r_lane      <= w_pick_lane;
          end
        end
        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            r_ld[r_lane] <= mem_rsp_data;
            r_pend_mask  <= w_pend_clr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Randomised bench for lsu_mem_sequencer against an op-level reference model.
// Latency: n/a (testbench).
// Backpressure: memory responder drives random/held ready and delayed responses.
module tb_lsu_mem_sequencer;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NT = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_is_store;
  logic [1:0]             req_warp;
  logic [NT-1:0]          req_mask;
  logic [NT-1:0][AW-1:0]  agu_addr;
  logic [NT-1:0][DW-1:0]  st_data;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic                   mem_req_we;
  logic [AW-1:0]          mem_req_addr;
  logic [DW-1:0]          mem_req_wdata;
  logic                   mem_rsp_valid;
  logic [DW-1:0]          mem_rsp_data;
  logic                   done_valid;
  logic [1:0]             done_warp;
  logic                   done_is_store;
  logic [NT-1:0]          done_mask;
  logic [NT-1:0][DW-1:0]  ld_data;
  logic                   busy;

  typedef struct {
    logic                  st;
    logic [1:0]            warp;
    logic [NT-1:0]         mask;
    logic [NT-1:0][AW-1:0] addr;
    logic [NT-1:0][DW-1:0] dat;
  } op_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            cyc;
  } mreq_t;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  mreq_t         obs_q[$];

  // responder controls
  int  hold_cnt  = 0;
  bit  rand_rdy  = 1'b0;
  int  rsp_max   = 0;
  bit  stray_en  = 1'b0;
  bit  stray_all = 1'b0;
  bit  mon_en    = 1'b1;
  bit  rsp_pend  = 1'b0;
  int  rsp_wait  = 0;
  logic [DW-1:0] rsp_dat;
  bit  stl_prev  = 1'b0;
  logic          stl_we;
  logic [AW-1:0] stl_addr;
  logic [DW-1:0] stl_wd;

  lsu_mem_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_THREADS(NT)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_is_store  (req_is_store),
    .req_warp      (req_warp),
    .req_mask      (req_mask),
    .agu_addr      (agu_addr),
    .st_data       (st_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .done_valid    (done_valid),
    .done_warp     (done_warp),
    .done_is_store (done_is_store),
    .done_mask     (done_mask),
    .ld_data       (ld_data),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: acts at negedges, so every input it drives is stable across the next rising edge.
  always @(negedge clk) begin
    bit hs;
    cyc++;
    if (mon_en && stl_prev) begin
      chk("stall_vld",  128'(mem_req_valid), 128'(1));
      chk("stall_we",   128'(mem_req_we),    128'(stl_we));
      chk("stall_addr", 128'(mem_req_addr),  128'(stl_addr));
      chk("stall_wd",   128'(mem_req_wdata), 128'(stl_wd));
    end
    if (hold_cnt > 0 && mem_req_valid) begin
      mem_req_ready = 1'b0;
      hold_cnt--;
    end else begin
      mem_req_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    hs       = mem_req_valid && mem_req_ready;
    stl_prev = mon_en && mem_req_valid && !mem_req_ready;
    stl_we   = mem_req_we;
    stl_addr = mem_req_addr;
    stl_wd   = mem_req_wdata;
    mem_rsp_valid = 1'b0;
    if (rsp_pend) begin
      if (rsp_wait == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rsp_dat;
        rsp_pend      = 1'b0;
      end else begin
        rsp_wait--;
      end
    end
    if (hs) begin
      obs_q.push_back('{mem_req_we, mem_req_addr, mem_req_wdata, cyc});
      if (mem_req_we) begin
        mem[mem_req_addr] = mem_req_wdata;
      end else begin
        rsp_pend = 1'b1;
        rsp_wait = $urandom_range(0, rsp_max);
        rsp_dat  = mem[mem_req_addr];
      end
    end else if (!rsp_pend && !mem_rsp_valid &&
                 (stray_all || (stray_en && $urandom_range(0, 3) == 0))) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 16'($urandom);
    end
  end

  task automatic chk_rst();
    chk("rst_req_ready", 128'(req_ready),     128'(0));
    chk("rst_busy",      128'(busy),          128'(0));
    chk("rst_mem_vld",   128'(mem_req_valid), 128'(0));
    chk("rst_mem_we",    128'(mem_req_we),    128'(0));
    chk("rst_mem_addr",  128'(mem_req_addr),  128'(0));
    chk("rst_mem_wd",    128'(mem_req_wdata), 128'(0));
    chk("rst_done",      128'(done_valid),    128'(0));
    chk("rst_done_warp", 128'(done_warp),     128'(0));
    chk("rst_done_st",   128'(done_is_store), 128'(0));
    chk("rst_done_mask", 128'(done_mask),     128'(0));
    chk("rst_ld_data",   ld_data,             128'(0));
  endtask

  function automatic int lat_of(input op_t o);
    int k;
    k = $countones(o.mask);
    if (k == 0) return 1;
    return o.st ? k + 1 : 2 * k + 1;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.st   = 1'($urandom_range(0, 1));
    o.warp = 2'($urandom);
    o.mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
    for (int i = 0; i < NT; i++) begin
      o.addr[i] = 8'($urandom_range(0, 31));
      o.dat[i]  = 16'($urandom);
    end
    return o;
  endfunction

  // One op end to end; returns at the negedge of the IDLE cycle after DONE.
  // keep=1 leaves req_valid high and presents nxt while this op runs.
  task automatic run_op(input op_t op, input bit keep, input op_t nxt, input int exp_lat);
    logic [NT-1:0][DW-1:0] exp_ld;
    mreq_t exp_q[$];
    int n;
    int w;
    exp_ld = '0;
    for (int i = 0; i < NT; i++) begin
      if (op.mask[i]) begin
        exp_q.push_back('{op.st, op.addr[i], op.st ? op.dat[i] : 16'h0, 0});
        if (op.st) ref_mem[op.addr[i]] = op.dat[i];
        else       exp_ld[i] = ref_mem[op.addr[i]];
      end
    end
    w = 0;
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_wait", 128'(req_ready), 128'(1));
    obs_q.delete();
    req_valid    = 1'b1;
    req_is_store = op.st;
    req_warp     = op.warp;
    req_mask     = op.mask;
    agu_addr     = op.addr;
    st_data      = op.dat;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if (keep) begin
          req_is_store = nxt.st;
          req_warp     = nxt.warp;
          req_mask     = nxt.mask;
          agu_addr     = nxt.addr;
          st_data      = nxt.dat;
        end else begin
          req_valid    = 1'b0;
          req_mask     = 8'($urandom);
          agu_addr     = {$urandom, $urandom};
          st_data      = {$urandom, $urandom, $urandom, $urandom};
        end
      end
    end while (!done_valid && n < 400);
    chk("done_seen", 128'(done_valid), 128'(1));
    if (exp_lat >= 0) chk("latency", 128'(n), 128'(exp_lat));
    chk("done_warp",     128'(done_warp),     128'(op.warp));
    chk("done_is_store", 128'(done_is_store), 128'(op.st));
    chk("done_mask",     128'(done_mask),     128'(op.mask));
    chk("ld_data",       ld_data,             exp_ld);
    chk("ready_in_done", 128'(req_ready),     128'(0));
    chk("busy_in_done",  128'(busy),          128'(1));
    chk("n_mem_req",     128'(obs_q.size()),  128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk("req_we",   128'(obs_q[i].we),   128'(exp_q[i].we));
      chk("req_addr", 128'(obs_q[i].addr), 128'(exp_q[i].addr));
      chk("req_wd",   128'(obs_q[i].wd),   128'(exp_q[i].wd));
    end
    @(negedge clk);
    chk("idle_busy",  128'(busy),      128'(0));
    chk("idle_ready", 128'(req_ready), 128'(1));
  endtask

  initial begin
    op_t a;
    op_t b;
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_warp     = '0;
    req_mask     = '0;
    agu_addr     = '0;
    st_data      = '0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'(i + 16'h100);
      ref_mem[i] = 16'(i + 16'h100);
    end

    repeat (3) @(negedge clk);
    chk_rst();
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy",  128'(busy),      128'(0));
    chk("post_rst_ready", 128'(req_ready), 128'(1));

    // sparse load, single-cycle response
    a.st = 1'b0; a.warp = 2'd2; a.mask = 8'h25;
    for (int i = 0; i < NT; i++) begin
      a.addr[i] = 8'(8'h30 + 3 * i);
      a.dat[i]  = 16'h5A00 + 16'(i);
    end
    run_op(a, 1'b0, a, 7);

    // full store
    a.st = 1'b1; a.warp = 2'd1; a.mask = 8'hFF;
    for (int i = 0; i < NT; i++) begin
      a.addr[i] = 8'(8'h10 + i);
      a.dat[i]  = 16'hA000 + 16'(i);
    end
    run_op(a, 1'b0, a, 9);

    // backpressure on lane 0
    a.st = 1'b1; a.warp = 2'd3; a.mask = 8'h03;
    a.addr[0] = 8'h50; a.addr[1] = 8'h51;
    hold_cnt = 4;
    run_op(a, 1'b0, a, 7);
    chk("bp_n_req", 128'(obs_q.size()), 128'(2));
    if (obs_q.size() == 2) chk("bp_lane1_gap", 128'(obs_q[1].cyc), 128'(obs_q[0].cyc + 1));

    // empty mask with stray responses
    a.st = 1'b0; a.warp = 2'd1; a.mask = 8'h00;
    stray_all = 1'b1;
    run_op(a, 1'b0, a, 1);
    stray_all = 1'b0;

    // back-to-back with req_valid held high
    a.st = 1'b1; a.warp = 2'd1; a.mask = 8'h0F;
    b.st = 1'b0; b.warp = 2'd2; b.mask = 8'h81;
    for (int i = 0; i < NT; i++) begin
      a.addr[i] = 8'(8'h60 + i);
      a.dat[i]  = 16'hC000 + 16'(i * 3);
      b.addr[i] = 8'(8'h60 + (i % 4));
      b.dat[i]  = 16'h0;
    end
    run_op(a, 1'b1, b, lat_of(a));
    run_op(b, 1'b0, b, lat_of(b));

    // reset while a request is stalled in ISSUE
    hold_cnt     = 1000;
    req_is_store = 1'b1;
    req_warp     = 2'd3;
    req_mask     = 8'hFF;
    agu_addr     = {8{8'h77}};
    st_data      = {8{16'hDEAD}};
    req_valid    = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_issue_vld", 128'(mem_req_valid), 128'(1));
    mon_en = 1'b0;
    reset  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_rst();
    end
    reset    = 1'b1;
    hold_cnt = 0;
    @(negedge clk);
    chk("abort_busy",  128'(busy),      128'(0));
    chk("abort_ready", 128'(req_ready), 128'(1));
    mon_en = 1'b1;

    // randomised ops
    for (int t = 0; t < 40; t++) begin
      a        = rand_op();
      rand_rdy = 1'($urandom_range(0, 1));
      rsp_max  = $urandom_range(0, 1) ? $urandom_range(0, 3) : 0;
      stray_en = 1'($urandom_range(0, 1));
      run_op(a, 1'b0, a, (!rand_rdy && rsp_max == 0) ? lat_of(a) : -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_chk, n_err);
    $fatal(1);
  end

endmodule
